rx_event_watchdog: RTL and testbench
====================================

Name: rx_event_watchdog

Overview:
Parametrised successor to the receiver's single-purpose signal watchdog. Takes N_EVENT per-cycle fault pulses from the receive chain (for example SIGNAL length out of range, DC running sum, small equalizer output, excessive phase offset). It keeps a saturating diagnostic counter and a sticky flag per event, and issues a receiver reset pulse of programmable length to the dot11 core. A programmable hold-off window after each reset suppresses reset storms. Counters and flags are cleared by an AXI-lite register write.

Parameters:
SEL_WIDTH, 3, event index width; N_EVENT = 2**SEL_WIDTH (8 events by default)
COUNTER_WIDTH, 22, width of every event counter and of the reset counter
RST_LEN_WIDTH, 4, width of the reset pulse length setting
HOLDOFF_WIDTH, 12, width of the hold-off length setting
CLR_ADDR, 5'd17, core register address whose write triggers clear

Ports:
clk  in  1  system clock (AXI clock domain)
rstn  in  1  synchronous active-low reset
enable  in  1  watchdog enable; gates counting and reset triggering
event_in  in  N_EVENT  per-cycle event pulses, bit i = event i
event_mask  in  N_EVENT  1 = event i may trigger receiver_rst
rst_pulse_len  in  RST_LEN_WIDTH  receiver_rst high time in cycles; 0 is treated as 1
holdoff_len  in  HOLDOFF_WIDTH  cycles after reset during which triggers are ignored
event_selector  in  SEL_WIDTH  selects which event counter drives event_counter
slv_reg_wren_signal  in  1  AXI-lite register write strobe
axi_awaddr_core  in  5  AXI-lite register write address (word index)
event_counter  out  COUNTER_WIDTH  selected event count (registered)
reset_counter  out  COUNTER_WIDTH  number of receiver resets issued
event_sticky  out  N_EVENT  bit i set on any counted occurrence of event i
last_event_idx  out  SEL_WIDTH  index of the event that caused the latest reset
receiver_rst  out  1  reset to the receiver core, registered
busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (rstn=0 at a clk edge):
  - all counters, event_sticky, last_event_idx, receiver_rst and busy are 0;
  - the FSM goes to IDLE;
  - the internal pulse and hold-off timers are 0.
- Clear: when slv_reg_wren_signal=1 and axi_awaddr_core==CLR_ADDR:
  - all event counters, reset_counter and event_sticky go to 0 at the next edge;
  - clear takes priority over any increment in the same cycle;
  - the FSM, receiver_rst and last_event_idx are unaffected.
- Counting:
  - When enable=1 and event_in[i]=1, counter i increments by 1 and event_sticky[i] sets, in every FSM state and regardless of event_mask.
  - Counters saturate at all-ones and never wrap.
  - Several bits may count in the same cycle.
- event_counter equals the counter selected by event_selector, registered with 1-cycle latency. A selector change shows at the output on the following cycle; a count update shows 1 cycle after the increment edge.
- trig = enable & |(event_in & event_mask).
- FSM:
  - IDLE: if trig, go to RST. On that edge:
    - receiver_rst<=1;
    - load the pulse timer with max(rst_pulse_len,1);
    - last_event_idx<=lowest set index of (event_in & event_mask);
    - reset_counter increments (saturating).
  - RST: the timer decrements each cycle and receiver_rst stays 1. When the timer reaches 1:
    - receiver_rst<=0;
    - if holdoff_len==0, go to IDLE;
    - otherwise load the hold-off timer with holdoff_len and go to HOLDOFF.
    - receiver_rst is high for exactly max(rst_pulse_len,1) cycles.
  - HOLDOFF: the timer decrements each cycle and trig is ignored (counting continues). When the timer reaches 1, go to IDLE. The earliest re-trigger is sampled on the first IDLE cycle.
- Latency: a masked event sampled at edge t gives receiver_rst=1 from edge t onward (1 register stage).
- enable dropping during RST or HOLDOFF does not shorten the pulse or the hold-off; the sequence completes.
- rst_pulse_len and holdoff_len are sampled only when the timers load; changes mid-sequence take effect on the next sequence.
- busy = (state != IDLE), registered along with the state.

Test Plan:
1. rstn low for 3 cycles with event_in=8'hFF → all outputs 0 and busy=0. After release with enable=1, event_in[2] pulsed 5 times, event_selector=2 → event_counter=5 one cycle after the last pulse; event_sticky=8'h04; receiver_rst stays 0 (mask=0).
2. event_mask=8'h10, rst_pulse_len=4, holdoff_len=10, single-cycle event_in[4] → receiver_rst high exactly 4 cycles starting 1 edge after the event; busy high 14 cycles; last_event_idx=4; reset_counter=1.
3. Same setup, a second event_in[4] during HOLDOFF → no new pulse, counter 4 = 2, reset_counter=1. An event on the first IDLE cycle → new pulse and reset_counter=2.
4. Simultaneous event_in=8'h28 with mask=8'hFF → last_event_idx=3, one reset pulse, counters 3 and 5 both 1. rst_pulse_len=0 → pulse width 1 cycle.
5. Preload counter 0 to 2^22-1 (force or long run), then one more event → stays 4194303. Write to address 17 on the same cycle as event_in[0] → counter 0 = 0 and event_sticky = 0. Write to address 16 → no clear.
6. enable dropped on cycle 2 of a 6-cycle pulse → pulse still 6 cycles. rstn asserted mid-HOLDOFF → next cycle IDLE, receiver_rst=0, counters 0.

Source files
------------

// File: rtl/rx_event_watchdog.sv
// Receiver event watchdog: per-event saturating counters and sticky flags, plus a
// receiver reset pulse generator with a post-reset hold-off window.
module rx_event_watchdog #(
  parameter int unsigned SEL_WIDTH     = 3,
  parameter int unsigned COUNTER_WIDTH = 22,
  parameter int unsigned RST_LEN_WIDTH = 4,
  parameter int unsigned HOLDOFF_WIDTH = 12,
  parameter logic [4:0]  CLR_ADDR      = 5'd17,
  localparam int unsigned N_EVENT      = 2**SEL_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic [N_EVENT-1:0]       event_in,
  input  logic [N_EVENT-1:0]       event_mask,
  input  logic [RST_LEN_WIDTH-1:0] rst_pulse_len,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_len,
  input  logic [SEL_WIDTH-1:0]     event_selector,
  input  logic                     slv_reg_wren_signal,
  input  logic [4:0]               axi_awaddr_core,
  output logic [COUNTER_WIDTH-1:0] event_counter,
  output logic [COUNTER_WIDTH-1:0] reset_counter,
  output logic [N_EVENT-1:0]       event_sticky,
  output logic [SEL_WIDTH-1:0]     last_event_idx,
  output logic                     receiver_rst,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_HOLDOFF} state_t;

  state_t                   r_state, w_state_nxt;
  logic [RST_LEN_WIDTH-1:0] r_pulse_tmr, w_pulse_tmr_nxt;
  logic [HOLDOFF_WIDTH-1:0] r_hold_tmr, w_hold_tmr_nxt;
  logic                     r_rst, w_rst_nxt;
  logic                     r_busy;
  logic [SEL_WIDTH-1:0]     r_last_idx, w_last_idx_nxt, w_low_idx;
  logic                     w_fire;
  logic [N_EVENT-1:0]       w_hit;
  logic                     w_trig;
  logic                     w_clr;

  logic [COUNTER_WIDTH-1:0] r_evt_cnt [N_EVENT];
  logic [COUNTER_WIDTH-1:0] r_rst_cnt;
  logic [COUNTER_WIDTH-1:0] r_event_counter;
  logic [N_EVENT-1:0]       r_sticky;

  assign w_hit  = event_in & event_mask;
  assign w_trig = enable & (|w_hit);
  assign w_clr  = slv_reg_wren_signal && (axi_awaddr_core == CLR_ADDR);

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    w_low_idx = '0;
    for (int unsigned i = N_EVENT; i > 0; i--) begin
      if (w_hit[i-1]) w_low_idx = SEL_WIDTH'(i - 1);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pulse_tmr_nxt = r_pulse_tmr;
    w_hold_tmr_nxt  = r_hold_tmr;
    w_rst_nxt       = r_rst;
    w_last_idx_nxt  = r_last_idx;
    w_fire          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_nxt     = S_RST;
          w_rst_nxt       = 1'b1;
          w_pulse_tmr_nxt = (rst_pulse_len == '0) ? RST_LEN_WIDTH'(1) : rst_pulse_len;
          w_last_idx_nxt  = w_low_idx;
          w_fire          = 1'b1;
        end
      end
      S_RST: begin
        if (r_pulse_tmr <= RST_LEN_WIDTH'(1)) begin
          w_rst_nxt = 1'b0;
          if (holdoff_len == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_hold_tmr_nxt = holdoff_len;
            w_state_nxt    = S_HOLDOFF;
          end
        end else begin
          w_pulse_tmr_nxt = r_pulse_tmr - RST_LEN_WIDTH'(1);
        end
      end
      S_HOLDOFF: begin
        if (r_hold_tmr <= HOLDOFF_WIDTH'(1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_tmr_nxt = r_hold_tmr - HOLDOFF_WIDTH'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_pulse_tmr <= '0;
      r_hold_tmr  <= '0;
      r_rst       <= 1'b0;
      r_busy      <= 1'b0;
      r_last_idx  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse_tmr <= w_pulse_tmr_nxt;
      r_hold_tmr  <= w_hold_tmr_nxt;
      r_rst       <= w_rst_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_last_idx  <= w_last_idx_nxt;
    end
  end

  // Register clear overrides any same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rstn || w_clr) begin
      for (int unsigned i = 0; i < N_EVENT; i++) r_evt_cnt[i] <= '0;
      r_sticky  <= '0;
      r_rst_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_EVENT; i++) begin
        if (enable && event_in[i]) begin
          if (r_evt_cnt[i] != '1) r_evt_cnt[i] <= r_evt_cnt[i] + COUNTER_WIDTH'(1);
          r_sticky[i] <= 1'b1;
        end
      end
      if (w_fire && (r_rst_cnt != '1)) r_rst_cnt <= r_rst_cnt + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_event_counter <= '0;
    else       r_event_counter <= r_evt_cnt[event_selector];
  end

  assign event_counter  = r_event_counter;
  assign reset_counter  = r_rst_cnt;
  assign event_sticky   = r_sticky;
  assign last_event_idx = r_last_idx;
  assign receiver_rst   = r_rst;
  assign busy           = r_busy;

endmodule

// File: tb/tb_rx_event_watchdog.sv
// Directed self-checking bench for rx_event_watchdog; a narrow-counter instance
// exercises saturation within a short run.
module tb_rx_event_watchdog;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        sat_en;
  logic [7:0]  event_in;
  logic [7:0]  event_mask;
  logic [3:0]  rst_pulse_len;
  logic [11:0] holdoff_len;
  logic [2:0]  event_selector;
  logic        wren;
  logic [4:0]  awaddr;

  logic [21:0] event_counter, reset_counter;
  logic [7:0]  event_sticky;
  logic [2:0]  last_event_idx;
  logic        receiver_rst, busy;

  logic [3:0]  s_event_counter, s_reset_counter;
  logic [7:0]  s_event_sticky;
  logic [2:0]  s_last_event_idx;
  logic        s_receiver_rst, s_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int rst_n, busy_n;

  always #5 clk = ~clk;

  rx_event_watchdog dut (
    .clk                 (clk),
    .rstn                (rstn),
    .enable              (enable),
    .event_in            (event_in),
    .event_mask          (event_mask),
    .rst_pulse_len       (rst_pulse_len),
    .holdoff_len         (holdoff_len),
    .event_selector      (event_selector),
    .slv_reg_wren_signal (wren),
    .axi_awaddr_core     (awaddr),
    .event_counter       (event_counter),
    .reset_counter       (reset_counter),
    .event_sticky        (event_sticky),
    .last_event_idx      (last_event_idx),
    .receiver_rst        (receiver_rst),
    .busy                (busy)
  );

  rx_event_watchdog #(.COUNTER_WIDTH(4)) u_sat (
    .clk                 (clk),
    .rstn                (rstn),
    .enable              (sat_en),
    .event_in            (event_in),
    .event_mask          (event_mask),
    .rst_pulse_len       (rst_pulse_len),
    .holdoff_len         (holdoff_len),
    .event_selector      (event_selector),
    .slv_reg_wren_signal (wren),
    .axi_awaddr_core     (awaddr),
    .event_counter       (s_event_counter),
    .reset_counter       (s_reset_counter),
    .event_sticky        (s_event_sticky),
    .last_event_idx      (s_last_event_idx),
    .receiver_rst        (s_receiver_rst),
    .busy                (s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; enable = 1'b0; sat_en = 1'b0; event_in = 8'hFF; event_mask = 8'h00;
    rst_pulse_len = 4'd0; holdoff_len = 12'd0; event_selector = 3'd0;
    wren = 1'b0; awaddr = 5'd0;

    // 1: reset state, then plain counting with no mask
    repeat (3) @(negedge clk);
    chk("rst_evcnt",   32'(event_counter), 0);
    chk("rst_rstcnt",  32'(reset_counter), 0);
    chk("rst_sticky",  32'(event_sticky), 0);
    chk("rst_last",    32'(last_event_idx), 0);
    chk("rst_rxrst",   32'(receiver_rst), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_s_cnt",   32'(s_event_counter), 0);
    chk("rst_s_rcnt",  32'(s_reset_counter), 0);
    chk("rst_s_misc",  32'({s_event_sticky, s_last_event_idx, s_receiver_rst, s_busy}), 0);

    rstn = 1'b1; enable = 1'b1; event_in = 8'h00; event_selector = 3'd2;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      event_in = 8'h04;
      @(negedge clk);
    end
    event_in = 8'h00;
    @(negedge clk);
    chk("t1_cnt2",    32'(event_counter), 5);
    chk("t1_sticky",  32'(event_sticky), 32'h04);
    chk("t1_rxrst",   32'(receiver_rst), 0);
    chk("t1_rstcnt",  32'(reset_counter), 0);

    // 2/3: pulse 4, hold-off 10, event in hold-off, re-trigger on first IDLE cycle
    event_mask = 8'h10; rst_pulse_len = 4'd4; holdoff_len = 12'd10; event_selector = 3'd4;
    event_in = 8'h10;
    @(negedge clk);
    event_in = 8'h00;
    rst_n = 0; busy_n = 0;
    for (int k = 1; k <= 15; k++) begin
      rst_n  += 32'(receiver_rst);
      busy_n += 32'(busy);
      if (k == 1) begin
        chk("t2_last",   32'(last_event_idx), 4);
        chk("t2_rstcnt", 32'(reset_counter), 1);
      end
      if (k == 14) begin
        chk("t3_cnt4_hold",   32'(event_counter), 2);
        chk("t3_rstcnt_hold", 32'(reset_counter), 1);
      end
      event_in = (k == 7 || k == 15) ? 8'h10 : 8'h00;
      @(negedge clk);
    end
    event_in = 8'h00;
    chk("t2_rst_width",  32'(rst_n), 4);
    chk("t2_busy_width", 32'(busy_n), 14);
    chk("t3_retrig",     32'(receiver_rst), 1);
    chk("t3_rstcnt2",    32'(reset_counter), 2);
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    chk("t3_done", 32'(busy), 0);

    // 4: simultaneous events, zero pulse length means 1 cycle
    event_mask = 8'hFF; rst_pulse_len = 4'd0; holdoff_len = 12'd0;
    event_in = 8'h28;
    @(negedge clk);
    event_in = 8'h00;
    chk("t4_rxrst",  32'(receiver_rst), 1);
    chk("t4_last",   32'(last_event_idx), 3);
    chk("t4_rstcnt", 32'(reset_counter), 3);
    @(negedge clk);
    chk("t4_width1", 32'(receiver_rst), 0);
    chk("t4_idle",   32'(busy), 0);
    event_selector = 3'd3;
    @(negedge clk);
    chk("t4_cnt3", 32'(event_counter), 1);
    event_selector = 3'd5;
    @(negedge clk);
    chk("t4_cnt5",   32'(event_counter), 1);
    chk("t4_sticky", 32'(event_sticky), 32'h3C);

    // 5: saturation (narrow instance), clear priority, wrong address
    event_mask = 8'h00; event_selector = 3'd0; sat_en = 1'b1;
    event_in = 8'h01;
    repeat (17) @(negedge clk);
    event_in = 8'h00;
    @(negedge clk);
    chk("t5_sat",      32'(s_event_counter), 15);
    chk("t5_nosat",    32'(event_counter), 17);
    chk("t5_s_sticky", 32'(s_event_sticky), 32'h01);
    chk("t5_s_rcnt",   32'(s_reset_counter), 0);
    wren = 1'b1; awaddr = 5'd17; event_in = 8'h01;
    @(negedge clk);
    wren = 1'b0; event_in = 8'h00;
    @(negedge clk);
    chk("t5_clr_cnt",    32'(event_counter), 0);
    chk("t5_clr_sticky", 32'(event_sticky), 0);
    chk("t5_clr_rstcnt", 32'(reset_counter), 0);
    chk("t5_clr_s_cnt",  32'(s_event_counter), 0);
    chk("t5_clr_last",   32'(last_event_idx), 3);
    event_in = 8'h01;
    @(negedge clk);
    event_in = 8'h00; wren = 1'b1; awaddr = 5'd16;
    @(negedge clk);
    wren = 1'b0;
    @(negedge clk);
    chk("t5_noclr_cnt",    32'(event_counter), 1);
    chk("t5_noclr_sticky", 32'(event_sticky), 32'h01);

    // 6: enable drop mid-pulse, then reset mid-hold-off
    sat_en = 1'b0; event_mask = 8'hFF; rst_pulse_len = 4'd6; holdoff_len = 12'd5;
    event_in = 8'h01;
    @(negedge clk);
    event_in = 8'h00;
    rst_n = 0;
    for (int k = 1; k <= 20; k++) begin
      rst_n += 32'(receiver_rst);
      if (k == 2) enable = 1'b0;
      @(negedge clk);
    end
    chk("t6_width", 32'(rst_n), 6);
    chk("t6_idle",  32'(busy), 0);
    enable = 1'b1; event_in = 8'h01;
    @(negedge clk);
    event_in = 8'h00;
    repeat (7) @(negedge clk);
    chk("t6_in_hold", 32'({busy, receiver_rst}), 32'b10);
    rstn = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy",   32'(busy), 0);
    chk("t6_rst_rxrst",  32'(receiver_rst), 0);
    chk("t6_rst_cnt",    32'(event_counter), 0);
    chk("t6_rst_rstcnt", 32'(reset_counter), 0);
    chk("t6_rst_sticky", 32'(event_sticky), 0);
    rstn = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
